// File: rtl/pwm_pkg.sv
// pwm_pkg: shared sizing for the PWM core and its register peripheral.
// Channel slice helpers locate channel fields inside the packed t/d buses.
package pwm_pkg;

  localparam int PWM_NCH   = 8;
  localparam int PWM_W     = 32;
  localparam int PWM_BUS_W = PWM_NCH * PWM_W;

  function automatic int pwm_lo(input int ch, input int w);
    return ch * w;
  endfunction

  function automatic int pwm_hi(input int ch, input int w);
    return ch * w + w - 1;
  endfunction

endpackage

// File: rtl/pwm_if.sv
// pwm_if: register-file to PWM core bundle.
// Master is the register side, slave is the PWM core.
interface pwm_if
  import pwm_pkg::*;
#(
  parameter int NCH = PWM_NCH,
  parameter int W   = PWM_W
);

  logic [NCH-1:0]   en;
  logic [NCH*W-1:0] t_bus;
  logic [NCH*W-1:0] d_bus;
  logic [NCH-1:0]   pwm;
  logic [NCH-1:0]   period_done;

  modport master (
    output en, t_bus, d_bus,
    input  pwm, period_done
  );

  modport slave (
    input  en, t_bus, d_bus,
    output pwm, period_done
  );

endinterface

// File: rtl/pwm_channel.sv
// pwm_channel: one double-buffered PWM channel.
// Period/duty are latched only at start or wrap.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int W = PWM_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] t,
  input  logic [W-1:0] d,
  output logic         pwm,
  output logic         period_done
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] t_act_q, t_act_d;
  logic [W-1:0] d_act_q, d_act_d;
  logic         run_q, run_d;
  logic         pwm_q, pwm_d;
  logic         done_q, done_d;
  logic [W:0]   cnt_inc;
  logic         wrap;

  // W+1-bit compare: t_act=0 always wraps, cnt=2^W-1 cannot overflow
  assign cnt_inc = {1'b0, cnt_q} + {{W{1'b0}}, 1'b1};
  assign wrap    = cnt_inc >= {1'b0, t_act_q};

  always_comb begin
    cnt_d   = cnt_q;
    t_act_d = t_act_q;
    d_act_d = d_act_q;
    run_d   = run_q;
    pwm_d   = pwm_q;
    done_d  = 1'b0;
    if (!en) begin
      run_d = 1'b0;
      cnt_d = '0;
      pwm_d = 1'b0;
    end else if (!run_q || wrap) begin
      t_act_d = t;
      d_act_d = d;
      cnt_d   = '0;
      run_d   = 1'b1;
      pwm_d   = d != '0;
      done_d  = run_q;
    end else begin
      cnt_d = cnt_inc[W-1:0];
      pwm_d = cnt_inc < {1'b0, d_act_q};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      t_act_q <= '0;
      d_act_q <= '0;
      run_q   <= 1'b0;
      pwm_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      t_act_q <= t_act_d;
      d_act_q <= d_act_d;
      run_q   <= run_d;
      pwm_q   <= pwm_d;
      done_q  <= done_d;
    end
  end

  assign pwm         = pwm_q;
  assign period_done = done_q;

endmodule

// File: rtl/pwm_core8.sv
// pwm_core8: NCH independent PWM channels fed from packed t/d buses.
// Pure structural wrapper around pwm_channel.
module pwm_core8
  import pwm_pkg::*;
#(
  parameter int NCH = PWM_NCH,
  parameter int W   = PWM_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH-1:0]   en,
  input  logic [NCH*W-1:0] t_bus,
  input  logic [NCH*W-1:0] d_bus,
  output logic [NCH-1:0]   pwm,
  output logic [NCH-1:0]   period_done
);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    pwm_channel #(.W(W)) u_ch (
      .clk         (clk),
      .reset       (reset),
      .en          (en[i]),
      .t           (t_bus[pwm_lo(i, W) +: W]),
      .d           (d_bus[pwm_lo(i, W) +: W]),
      .pwm         (pwm[i]),
      .period_done (period_done[i])
    );
  end

endmodule
